oled_fb_scanner: RTL and testbench

Reads the 1024-byte OLED framebuffer from the dual-port RAM (myram) read port and streams it to the SPI byte transmitter as a command/data byte sequence. For each page it emits a page-address command and two column-address commands, then COLS data bytes. A frame refresh runs on each start pulse. It sits directly downstream of the framebuffer RAM and upstream of the SPI byte serializer.

---
 rtl/oled_pkg.sv | 38 +++
 rtl/oled_fb_scanner.sv | 156 +++++++++++++++
 tb/tb_oled_fb_scanner.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oled_pkg.sv
`default_nettype none
// ============================================================================
// Module      : oled_pkg
// Description : Shared definitions for the OLED framebuffer scanner: scanner
//               state encoding, SSD1306/SH1106 addressing command bytes and
//               default display geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package oled_pkg;

    // Default geometry of a 128x64 panel: 8 pages of 8 pixel rows each.
    localparam int OLED_PAGES = 8;
    localparam int OLED_COLS  = 128;

    // Addressing command bases; the low nibble carries the page / column.
    localparam logic [7:0] OLED_CMD_PAGE   = 8'hB0;
    localparam logic [7:0] OLED_CMD_COL_LO = 8'h00;
    localparam logic [7:0] OLED_CMD_COL_HI = 8'h10;

    // Scanner states, explicit 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD_PG = 3'd1,
        ST_CMD_LO = 3'd2,
        ST_CMD_HI = 3'd3,
        ST_RD     = 3'd4,
        ST_LATCH  = 3'd5,
        ST_DATA   = 3'd6,
        ST_FIN    = 3'd7
    } oled_state_e;

    // Page-address command for a given page number.
    function automatic logic [7:0] oled_page_cmd(input logic [7:0] page);
        return OLED_CMD_PAGE | page;
    endfunction

endpackage : oled_pkg
`default_nettype wire

// File: rtl/oled_fb_scanner.sv
`default_nettype none
// ============================================================================
// Module      : oled_fb_scanner
// Description : Walks the OLED framebuffer RAM page by page and streams it to
//               the SPI byte transmitter. Each page is preceded by a page
//               address command and the two column address commands; then
//               COLS display-data bytes follow. One frame per start pulse.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               start          - one-cycle pulse, frame request (ignored if busy)
//               busy / done    - frame in progress / one-cycle end-of-frame
//               rd_addr/rd_data- RAM read port, one-cycle synchronous read
//               tx_data/tx_dc  - byte and command(0)/data(1) flag
//               tx_valid/ready - valid/ready handshake to the serializer
// Revision    : 1.0 - initial release
// ============================================================================
module oled_fb_scanner
    import oled_pkg::*;
#(
    parameter int PAGES      = OLED_PAGES,
    parameter int COLS       = OLED_COLS,
    parameter int ADDR_W     = 10,      // 2**ADDR_W must cover PAGES*COLS
    parameter int COL_OFFSET = 0        // first visible column (2 on SH1106)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_dc,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int         c_pg_w   = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int         c_col_w  = (COLS > 1)  ? $clog2(COLS)  : 1;
    localparam logic [7:0] c_off    = 8'(COL_OFFSET);
    localparam logic [7:0] c_col_lo = OLED_CMD_COL_LO | {4'h0, c_off[3:0]};
    localparam logic [7:0] c_col_hi = OLED_CMD_COL_HI | {4'h0, c_off[7:4]};

    oled_state_e          r_state;
    logic [c_pg_w-1:0]    r_page;
    logic [c_col_w-1:0]   r_col;

    logic                 w_xfer;
    logic                 w_last_col;
    logic                 w_last_pg;
    logic [ADDR_W-1:0]    w_page_base;

    assign w_xfer      = tx_valid && tx_ready;
    assign w_last_col  = (r_col  == c_col_w'(COLS - 1));
    assign w_last_pg   = (r_page == c_pg_w'(PAGES - 1));
    assign w_page_base = ADDR_W'(r_page) * ADDR_W'(COLS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_page   <= '0;
            r_col    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_addr  <= '0;
            tx_data  <= 8'h00;
            tx_dc    <= 1'b0;
            tx_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_page   <= '0;
                        r_col    <= '0;
                        busy     <= 1'b1;
                        tx_data  <= oled_page_cmd(8'd0);
                        tx_dc    <= 1'b0;
                        tx_valid <= 1'b1;
                        r_state  <= ST_CMD_PG;
                    end
                end

                ST_CMD_PG: begin
                    if (w_xfer) begin
                        tx_data <= c_col_lo;
                        r_state <= ST_CMD_LO;
                    end
                end

                ST_CMD_LO: begin
                    if (w_xfer) begin
                        tx_data <= c_col_hi;
                        r_state <= ST_CMD_HI;
                    end
                end

                ST_CMD_HI: begin
                    if (w_xfer) begin
                        // Address goes out on the same edge that enters RD so
                        // the RAM sees a stable address for the whole RD cycle.
                        tx_valid <= 1'b0;
                        r_col    <= '0;
                        rd_addr  <= w_page_base;
                        r_state  <= ST_RD;
                    end
                end

                ST_RD: begin
                    // RAM registers rd_addr at the end of this cycle.
                    r_state <= ST_LATCH;
                end

                ST_LATCH: begin
                    // Read data is only valid now, one cycle after the address.
                    tx_data  <= rd_data;
                    tx_dc    <= 1'b1;
                    tx_valid <= 1'b1;
                    r_state  <= ST_DATA;
                end

                ST_DATA: begin
                    if (w_xfer) begin
                        tx_valid <= 1'b0;
                        if (!w_last_col) begin
                            // Columns of a page are contiguous in RAM.
                            r_col   <= r_col + c_col_w'(1);
                            rd_addr <= rd_addr + ADDR_W'(1);
                            r_state <= ST_RD;
                        end else if (!w_last_pg) begin
                            r_page   <= r_page + c_pg_w'(1);
                            r_col    <= '0;
                            tx_data  <= oled_page_cmd(8'(r_page) + 8'd1);
                            tx_dc    <= 1'b0;
                            tx_valid <= 1'b1;
                            r_state  <= ST_CMD_PG;
                        end else begin
                            done    <= 1'b1;
                            r_state <= ST_FIN;
                        end
                    end
                end

                ST_FIN: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : oled_fb_scanner
`default_nettype wire

// File: tb/tb_oled_fb_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_oled_fb_scanner
// Description : Scoreboard bench for oled_fb_scanner. Expected byte streams
//               are built from the display geometry and queued when a frame is
//               requested; a negedge monitor pops and compares every transfer.
//               A second instance runs with COL_OFFSET=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oled_fb_scanner;

    localparam int PAGES  = 8;
    localparam int COLS   = 128;
    localparam int ADDR_W = 10;
    localparam int NXFER  = PAGES * (3 + COLS);      // 1048
    localparam int NCYC   = PAGES * (3 + 3 * COLS);  // 3096

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------- RAM
    logic [7:0] mem [0:(1<<ADDR_W)-1];
    initial for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 8'(a);

    // ---------------------------------------------------------------- DUT 0
    logic              start0 = 1'b0;
    logic              busy0, done0, tx_dc0, tx_valid0;
    logic              tx_ready0 = 1'b1;
    logic [ADDR_W-1:0] rd_addr0, addr_q0;
    logic [7:0]        rd_data0, ram_q0, tx_data0;

    // Synchronous read; output is garbage (0xEE) in the cycle the address moved.
    always @(posedge clk) begin
        ram_q0  <= mem[rd_addr0];
        addr_q0 <= rd_addr0;
    end
    assign rd_data0 = (rd_addr0 != addr_q0) ? 8'hEE : ram_q0;

    oled_fb_scanner #(.PAGES(PAGES), .COLS(COLS), .ADDR_W(ADDR_W), .COL_OFFSET(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .rd_addr(rd_addr0), .rd_data(rd_data0), .tx_data(tx_data0), .tx_dc(tx_dc0),
        .tx_valid(tx_valid0), .tx_ready(tx_ready0)
    );

    // ---------------------------------------------------------------- DUT 2
    logic              start2 = 1'b0;
    logic              busy2, done2, tx_dc2, tx_valid2;
    logic              tx_ready2 = 1'b1;
    logic [ADDR_W-1:0] rd_addr2, addr_q2;
    logic [7:0]        rd_data2, ram_q2, tx_data2;

    always @(posedge clk) begin
        ram_q2  <= mem[rd_addr2];
        addr_q2 <= rd_addr2;
    end
    assign rd_data2 = (rd_addr2 != addr_q2) ? 8'hEE : ram_q2;

    oled_fb_scanner #(.PAGES(PAGES), .COLS(COLS), .ADDR_W(ADDR_W), .COL_OFFSET(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .rd_addr(rd_addr2), .rd_data(rd_data2), .tx_data(tx_data2), .tx_dc(tx_dc2),
        .tx_valid(tx_valid2), .tx_ready(tx_ready2)
    );

    // ---------------------------------------------------------------- scoreboard
    logic [8:0] exp0 [$];   // {dc, byte}
    logic [8:0] exp2 [$];

    task automatic push_frame(input bit which, input int off);
        logic [7:0] o;
        logic [8:0] e;
        o = 8'(off);
        for (int p = 0; p < PAGES; p++) begin
            for (int k = 0; k < 3 + COLS; k++) begin
                if (k == 0)      e = {1'b0, 8'hB0 | 8'(p)};
                else if (k == 1) e = {1'b0, 4'h0, o[3:0]};
                else if (k == 2) e = {1'b0, 4'h1, o[7:4]};
                else             e = {1'b1, 8'(p * COLS + (k - 3))};
                if (which) exp2.push_back(e);
                else       exp0.push_back(e);
            end
        end
    endtask

    // Per-frame bookkeeping for DUT 0.
    int xfer0, done_cnt0, first_cyc0, last_cyc0;
    bit stall_prev0;
    logic [8:0] prev_byte0;
    int xfer2, done_cnt2;

    task automatic clear_stats0();
        xfer0 = 0; done_cnt0 = 0; first_cyc0 = -1; last_cyc0 = -10;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall_prev0 = 1'b0;
        end else begin
            if (stall_prev0) begin
                check("stall_valid_hold", 32'(tx_valid0), 32'd1);
                check("stall_byte_hold", 32'({tx_dc0, tx_data0}), 32'(prev_byte0));
            end
            if (tx_valid0 && first_cyc0 < 0) first_cyc0 = cyc;
            if (tx_valid0 && tx_ready0) begin
                check("xfer_expected", 32'(exp0.size() != 0), 32'd1);
                if (exp0.size() != 0) check($sformatf("byte%0d", xfer0),
                                            32'({tx_dc0, tx_data0}), 32'(exp0.pop_front()));
                xfer0++;
                last_cyc0 = cyc;
            end
            if (done0) begin
                done_cnt0++;
                check("busy_in_fin", 32'(busy0), 32'd1);
                check("done_after_last", 32'(cyc), 32'(last_cyc0 + 1));
            end
            stall_prev0 = tx_valid0 && !tx_ready0;
            prev_byte0  = {tx_dc0, tx_data0};
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_valid2 && tx_ready2) begin
                check("xfer2_expected", 32'(exp2.size() != 0), 32'd1);
                if (exp2.size() != 0) check($sformatf("off2_byte%0d", xfer2),
                                            32'({tx_dc2, tx_data2}), 32'(exp2.pop_front()));
                xfer2++;
            end
            if (done2) done_cnt2++;
        end
    end

    // Ready driver: changes just after the active edge.
    bit rdy_rand = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        tx_ready0 = rdy_rand ? ($urandom_range(0, 9) < 3) : 1'b1;
    end

    // ---------------------------------------------------------------- tasks
    int s_cyc;

    task automatic pulse_start0();
        @(posedge clk); #1;
        start0 = 1'b1;
        @(posedge clk); #1;
        s_cyc  = cyc;
        start0 = 1'b0;
    endtask

    task automatic wait_done0(input int lim);
        int i = 0;
        while (!done0 && i < lim) begin
            @(negedge clk);
            i++;
        end
        check("done0_seen", 32'(done0), 32'd1);
    endtask

    task automatic post_frame0(input string tag);
        repeat (5) @(negedge clk);
        check({tag, "_xfers"}, 32'(xfer0), 32'(NXFER));
        check({tag, "_dones"}, 32'(done_cnt0), 32'd1);
        check({tag, "_queue_empty"}, 32'(exp0.size()), 32'd0);
        check({tag, "_busy_idle"}, 32'(busy0), 32'd0);
        check({tag, "_valid_idle"}, 32'(tx_valid0), 32'd0);
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        clear_stats0();
        xfer2 = 0; done_cnt2 = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_valid", 32'(tx_valid0), 32'd0);
        check("rst_data", 32'(tx_data0), 32'h00);
        check("rst_dc", 32'(tx_dc0), 32'd0);
        check("rst_addr", 32'(rd_addr0), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full frame, no backpressure, latency figures.
        clear_stats0();
        push_frame(1'b0, 0);
        pulse_start0();
        wait_done0(NCYC + 100);
        check("first_valid_latency", 32'(first_cyc0), 32'(s_cyc));
        check("frame_cycles", 32'(last_cyc0 - first_cyc0 + 1), 32'(NCYC));
        post_frame0("full");

        // Backpressure: same stream, stable bytes under stall.
        rdy_rand = 1'b1;
        clear_stats0();
        push_frame(1'b0, 0);
        pulse_start0();
        wait_done0(20 * NCYC);
        rdy_rand = 1'b1;
        post_frame0("bp");
        rdy_rand = 1'b0;
        repeat (2) @(negedge clk);

        // Starts during a running frame and in FIN are dropped.
        clear_stats0();
        push_frame(1'b0, 0);
        pulse_start0();
        repeat (50) @(posedge clk);
        #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        wait_done0(NCYC + 100);
        start0 = 1'b1;                 // lands on the edge that leaves FIN
        @(posedge clk); #1 start0 = 1'b0;
        repeat (20) @(negedge clk);
        post_frame0("restart_ignored");

        // Asynchronous reset in page-3 data.
        clear_stats0();
        push_frame(1'b0, 0);
        pulse_start0();
        begin
            int i = 0;
            while (xfer0 < 3 * (3 + COLS) + 3 + 10 && i < NCYC) begin
                @(negedge clk);
                i++;
            end
        end
        check("reached_page3", 32'(xfer0 >= 3 * (3 + COLS) + 3 + 10), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(tx_valid0), 32'd0);
        check("async_rst_busy", 32'(busy0), 32'd0);
        check("async_rst_addr", 32'(rd_addr0), 32'd0);
        exp0.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        clear_stats0();
        push_frame(1'b0, 0);
        pulse_start0();
        wait_done0(NCYC + 100);
        post_frame0("after_rst");

        // COL_OFFSET=2 instance.
        push_frame(1'b1, 2);
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        begin
            int i = 0;
            while (!done2 && i < NCYC + 100) begin
                @(negedge clk);
                i++;
            end
        end
        repeat (5) @(negedge clk);
        check("off2_xfers", 32'(xfer2), 32'(NXFER));
        check("off2_dones", 32'(done_cnt2), 32'd1);
        check("off2_queue_empty", 32'(exp2.size()), 32'd0);
        check("off2_busy_idle", 32'(busy2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule : tb_oled_fb_scanner
`default_nettype wire
